difftest_int_wb_collector: RTL and testbench

Collects integer register-file writebacks from the core's parallel writeback ports and serializes them into a single one-record-per-cycle stream for the `DifftestIntWriteback` DPI bridge. Writebacks are buffered in a circular FIFO, pushed in port order and drained one per cycle. The core's writeback path never stalls, so overflow drops records and raises a sticky flag.

---
 rtl/difftest_pkg.sv | 13 +
 rtl/wb_port_packer.sv | 28 ++
 rtl/difftest_int_wb_collector.sv | 109 ++++++++++
 tb/tb_difftest_int_wb_collector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared types and widths for the difftest writeback collectors.
package difftest_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 8;
    localparam int COREID_W   = 8;

    typedef struct packed {
        logic [7:0]  addr;
        logic [63:0] data;
    } int_wb_rec_t;

endpackage

// File: rtl/wb_port_packer.sv
// Compacts eligible writeback ports into consecutive slots (lowest port first)
// and reports how many ports are eligible this cycle.
module wb_port_packer #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    parameter int CNT_W     = $clog2(NUM_PORTS + 1)
) (
    input  logic [NUM_PORTS-1:0]       valid,
    input  logic [NUM_PORTS-1:0]       elig,
    output logic [NUM_PORTS*IDX_W-1:0] slot_port,
    output logic [CNT_W-1:0]           count
);

    always_comb begin
        int pos;
        slot_port = '0;
        pos       = 0;
        // Running prefix count of eligible ports gives each one its slot.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (valid[i] && elig[i]) begin
                slot_port[pos*IDX_W +: IDX_W] = IDX_W'(i);
                pos = pos + 1;
            end
        end
        count = CNT_W'(pos);
    end

endmodule

// File: rtl/difftest_int_wb_collector.sv
// Buffers parallel integer writebacks in a circular FIFO and drains them one
// record per cycle towards the DifftestIntWriteback bridge.
module difftest_int_wb_collector
    import difftest_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 16,
    parameter bit DROP_X0   = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        wb_valid,
    input  logic [NUM_PORTS*8-1:0]      wb_address,
    input  logic [NUM_PORTS*64-1:0]     wb_data,
    input  logic [7:0]                  coreid,
    output logic                        out_enable,
    output logic [7:0]                  out_address,
    output logic [63:0]                 out_data,
    output logic [7:0]                  out_coreid,
    output logic                        overflow,
    output logic [$clog2(DEPTH+1)-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(NUM_PORTS + 1);

    int_wb_rec_t                 mem [DEPTH];
    int_wb_rec_t                 recs [NUM_PORTS];
    logic [NUM_PORTS-1:0]        elig;
    logic [NUM_PORTS*IDX_W-1:0]  slot_port;
    logic [IDX_W-1:0]            slot_idx [NUM_PORTS];
    logic [CNT_W-1:0]            elig_cnt;
    logic [PTR_W-1:0]            wptr;
    logic [PTR_W-1:0]            rptr;
    logic [LVL_W-1:0]            free_slots;
    logic [LVL_W-1:0]            pushed;
    logic                        pop;
    logic                        drop;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i]      = wb_valid[i] && (!DROP_X0 || (wb_address[i*8 +: 8] != 8'd0));
            recs[i].addr = wb_address[i*8 +: 8];
            recs[i].data = wb_data[i*64 +: 64];
            slot_idx[i]  = slot_port[i*IDX_W +: IDX_W];
        end
    end

    wb_port_packer #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W),
        .CNT_W     (CNT_W)
    ) u_packer (
        .valid     (wb_valid),
        .elig      (elig),
        .slot_port (slot_port),
        .count     (elig_cnt)
    );

    // Free space is taken from the pre-pop level: a slot vacated this cycle
    // only becomes writable on the next one.
    always_comb begin
        free_slots = LVL_W'(DEPTH) - level;
        if (LVL_W'(elig_cnt) < free_slots) begin
            pushed = LVL_W'(elig_cnt);
        end else begin
            pushed = free_slots;
        end
        drop = LVL_W'(elig_cnt) > free_slots;
        pop  = level != '0;
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (LVL_W'(k) < pushed) begin
                mem[wptr + PTR_W'(k)] <= recs[slot_idx[k]];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            out_enable  <= 1'b0;
            out_address <= '0;
            out_data    <= '0;
            out_coreid  <= '0;
        end else begin
            wptr       <= wptr + PTR_W'(pushed);
            level      <= level + pushed - LVL_W'(pop);
            out_enable <= pop;
            out_coreid <= coreid;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rptr        <= rptr + 1'b1;
                out_address <= mem[rptr].addr;
                out_data    <= mem[rptr].data;
            end
        end
    end

endmodule

// File: tb/tb_difftest_int_wb_collector.sv
// Directed bench for difftest_int_wb_collector (NUM_PORTS=4, DEPTH=16, DROP_X0=1).
module tb_difftest_int_wb_collector;

    logic         clock;
    logic         reset;
    logic [3:0]   wb_valid;
    logic [31:0]  wb_address;
    logic [255:0] wb_data;
    logic [7:0]   coreid;
    logic         out_enable;
    logic [7:0]   out_address;
    logic [63:0]  out_data;
    logic [7:0]   out_coreid;
    logic         overflow;
    logic [4:0]   level;

    int total;
    int bad;
    int max_level;
    logic [71:0] got [$];
    logic [71:0] expq [$];

    difftest_int_wb_collector #(
        .NUM_PORTS (4),
        .DEPTH     (16),
        .DROP_X0   (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wb_valid    (wb_valid),
        .wb_address  (wb_address),
        .wb_data     (wb_data),
        .coreid      (coreid),
        .out_enable  (out_enable),
        .out_address (out_address),
        .out_data    (out_data),
        .out_coreid  (out_coreid),
        .overflow    (overflow),
        .level       (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Advance one cycle and record any record presented on the output.
    task automatic tick_collect();
        @(negedge clock);
        if (out_enable) got.push_back({out_address, out_data});
        if (int'(level) > max_level) max_level = int'(level);
    endtask

    task automatic idle_inputs();
        wb_valid   = '0;
        wb_address = '0;
        wb_data    = '0;
    endtask

    task automatic drive_port(input int p, input logic [7:0] a, input logic [63:0] d);
        wb_valid[p]          = 1'b1;
        wb_address[p*8 +: 8] = a;
        wb_data[p*64 +: 64]  = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        coreid = 8'h3;
        idle_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        tick();
        chk("rst_enable", {71'd0, out_enable}, 72'd0);
        chk("rst_level", {67'd0, level}, 72'd0);
        chk("rst_overflow", {71'd0, overflow}, 72'd0);
        chk("rst_coreid", {64'd0, out_coreid}, 72'd0);
        reset = 1'b1;

        // Single write: level 1 next cycle, record out the cycle after.
        drive_port(0, 8'd5, 64'hDEAD_BEEF);
        tick();
        idle_inputs();
        chk("single_level1", {67'd0, level}, 72'd1);
        chk("single_en0", {71'd0, out_enable}, 72'd0);
        chk("coreid_reg", {64'd0, out_coreid}, 72'h3);
        tick();
        chk("single_en1", {71'd0, out_enable}, 72'd1);
        chk("single_rec", {out_address, out_data}, {8'd5, 64'hDEAD_BEEF});
        chk("single_level0", {67'd0, level}, 72'd0);
        tick();
        chk("single_en_off", {71'd0, out_enable}, 72'd0);
        chk("single_addr_hold", {64'd0, out_address}, 72'd5);

        // Port ordering: four ports in one cycle drain as 1,2,3,4.
        for (int p = 0; p < 4; p++) drive_port(p, 8'(p + 1), 64'h100 + 64'(p));
        tick();
        idle_inputs();
        chk("order_peak", {67'd0, level}, 72'd4);
        for (int p = 0; p < 4; p++) begin
            tick();
            chk("order_en", {71'd0, out_enable}, 72'd1);
            chk("order_rec", {out_address, out_data}, {8'(p + 1), 64'h100 + 64'(p)});
            chk("order_level", {67'd0, level}, 72'(3 - p));
        end
        tick();
        chk("order_done", {71'd0, out_enable}, 72'd0);

        // x0 filtering: port 0 writes x0, port 2 writes x7.
        drive_port(0, 8'd0, 64'hAAAA);
        drive_port(2, 8'd7, 64'h7777);
        tick();
        idle_inputs();
        chk("x0_level", {67'd0, level}, 72'd1);
        tick();
        chk("x0_rec", {out_address, out_data}, {8'd7, 64'h7777});
        tick();
        chk("x0_single", {71'd0, out_enable}, 72'd0);
        chk("x0_no_ovf", {71'd0, overflow}, 72'd0);

        // Overflow: 6 cycles of 4 writes. Levels after edges: 4,7,10,13,15,15.
        // Cycle 5 keeps 17..19 (drops 20), cycle 6 keeps only 21.
        got.delete();
        expq.delete();
        for (int n = 1; n <= 19; n++) expq.push_back({8'(n), 64'h1000 + 64'(n)});
        expq.push_back({8'd21, 64'h1000 + 64'd21});
        for (int c = 0; c < 6; c++) begin
            for (int p = 0; p < 4; p++) drive_port(p, 8'(c*4 + p + 1), 64'h1000 + 64'(c*4 + p + 1));
            tick_collect();
            if (c == 3) chk("ovf_before", {71'd0, overflow}, 72'd0);
            if (c == 4) chk("ovf_set", {71'd0, overflow}, 72'd1);
            if (c == 5) chk("ovf_full_level", {67'd0, level}, 72'd15);
        end
        idle_inputs();
        for (int c = 0; c < 24; c++) tick_collect();
        chk("ovf_count", 72'(got.size()), 72'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            chk("ovf_rec", (i < got.size()) ? got[i] : '1, expq[i]);
        chk("ovf_sticky", {71'd0, overflow}, 72'd1);

        // Wrap-around: 40 records at one per cycle.
        got.delete();
        expq.delete();
        max_level = 0;
        for (int n = 0; n < 40; n++) begin
            idle_inputs();
            drive_port(n % 4, 8'(n + 10), 64'hC0DE_0000_0000_0000 + 64'(n * 3));
            expq.push_back({8'(n + 10), 64'hC0DE_0000_0000_0000 + 64'(n * 3)});
            tick_collect();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) tick_collect();
        chk("wrap_count", 72'(got.size()), 72'd40);
        for (int i = 0; i < 40; i++)
            chk("wrap_rec", (i < got.size()) ? got[i] : '1, expq[i]);
        chk("wrap_level_le2", 72'(max_level <= 2), 72'd1);

        // Reset mid-drain with level 10.
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 4; p++) drive_port(p, 8'(50 + c*4 + p), 64'h5000 + 64'(c*4 + p));
            tick();
        end
        idle_inputs();
        chk("mid_level10", {67'd0, level}, 72'd10);
        chk("mid_draining", {71'd0, out_enable}, 72'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_enable", {71'd0, out_enable}, 72'd0);
        chk("async_level", {67'd0, level}, 72'd0);
        chk("async_addr", {64'd0, out_address}, 72'd0);
        chk("async_data", {8'd0, out_data}, 72'd0);
        chk("async_coreid", {64'd0, out_coreid}, 72'd0);
        chk("async_overflow", {71'd0, overflow}, 72'd0);
        tick();
        tick();
        reset = 1'b1;
        drive_port(1, 8'd9, 64'h9999);
        tick();
        idle_inputs();
        chk("post_level", {67'd0, level}, 72'd1);
        chk("post_en0", {71'd0, out_enable}, 72'd0);
        tick();
        chk("post_en1", {71'd0, out_enable}, 72'd1);
        chk("post_rec", {out_address, out_data}, {8'd9, 64'h9999});
        tick();
        chk("post_only", {71'd0, out_enable}, 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
